// File: rtl/zircon_avalon_buzzer_sequencer_pkg.sv
// Shared definitions for the buzzer note sequencer: register map,
// CTRL/STATUS bit positions, FSM encoding and the note queue entry.
package zircon_buzzer_pkg;

    localparam logic [1:0] ADDR_DIVIDE = 2'd0;
    localparam logic [1:0] ADDR_DUTY   = 2'd1;
    localparam logic [1:0] ADDR_LEN    = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_CLEAR  = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STAT_RUN    = 0;
    localparam int STAT_BUSY   = 1;
    localparam int STAT_EMPTY  = 2;
    localparam int STAT_FULL   = 3;
    localparam int STAT_OVF    = 4;
    localparam int STAT_DONE   = 5;
    localparam int STAT_IRQ_EN = 6;
    localparam int STAT_LEVEL  = 8;

    localparam int NOTE_W = 80;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP,
        FINISH
    } seq_state_t;

    typedef struct packed {
        logic [31:0] divide;
        logic [31:0] duty;
        logic [15:0] len;
    } note_t;

endpackage

// File: rtl/zircon_avalon_buzzer_sequencer_if.sv
// Avalon-MM slave port bundle of the buzzer note sequencer.
interface zircon_avalon_buzzer_sequencer_if;

    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_write,
        output avs_writedata,
        output avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_write,
        input  avs_writedata,
        input  avs_read,
        output avs_readdata
    );

endinterface

// File: rtl/zircon_avalon_buzzer_sequencer_note_fifo.sv
// Synchronous note queue with flush; a push into a full queue is
// accepted only when a pop happens in the same cycle.
module zircon_buzzer_note_fifo
    import zircon_buzzer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = NOTE_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = level == '0;
    assign full     = level == (AW+1)'(DEPTH);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && !do_push;
    assign rdata    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/zircon_avalon_buzzer_sequencer.sv
// Avalon-MM buzzer note sequencer feeding the PWM core.
// Optional ZIRCON_BUZZER_SEQ_IRQ_EN adds a DONE interrupt (CTRL bit3).
module zircon_avalon_buzzer_sequencer
    import zircon_buzzer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TICK_DIV   = 50000,
    parameter int GAP_TICKS  = 10
) (
    input  logic                            csi_clk,
    input  logic                            rsi_reset_n,
    zircon_avalon_buzzer_sequencer_if.slave avs,
    output logic                            pwm_enable,
    output logic [31:0]                     pwm_clock_divide,
    output logic [31:0]                     pwm_duty_cycle,
    output logic                            ins_irq
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    seq_state_t    state;
    seq_state_t    next_state;
    note_t         head;
    note_t         push_note;
    logic [31:0]   stage_divide;
    logic [31:0]   stage_duty;
    logic [31:0]   cur_divide;
    logic [31:0]   cur_duty;
    logic [31:0]   tick_cnt;
    logic [31:0]   status;
    logic [15:0]   remaining;
    logic [LW-1:0] level;
    logic          run;
    logic          ovf;
    logic          done;
    logic          flush_q;
    logic          irq_en;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          wr_divide;
    logic          wr_duty;
    logic          wr_ctrl;
    logic          clr;
    logic          timing_on;
    logic          tick;
    logic          last;
    logic          gap_done;
    logic          load_note;
    logic          play;
    logic          finish;
    logic          busy;

    assign wr_divide = avs.avs_write && avs.avs_address == ADDR_DIVIDE;
    assign wr_duty   = avs.avs_write && avs.avs_address == ADDR_DUTY;
    assign push      = avs.avs_write && avs.avs_address == ADDR_LEN;
    assign wr_ctrl   = avs.avs_write && avs.avs_address == ADDR_CTRL;
    assign clr       = wr_ctrl && avs.avs_writedata[CTRL_CLEAR];
    assign push_note = {stage_divide, stage_duty, avs.avs_writedata[15:0]};

    zircon_buzzer_note_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (NOTE_W)
    ) u_fifo (
        .clk      (csi_clk),
        .rst_n    (rsi_reset_n),
        .flush    (flush_q),
        .push     (push),
        .pop      (pop),
        .wdata    (push_note),
        .rdata    (head),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .level    (level)
    );

    assign timing_on = state == PLAY || state == GAP;
    assign tick      = timing_on && tick_cnt == 32'(TICK_DIV - 1);
    assign last      = tick && remaining == 16'd1;
    assign gap_done  = (GAP_TICKS == 0) || last;

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:
                if (run && !empty)
                    next_state = LOAD;
            LOAD:
                if (empty)
                    next_state = FINISH;
                else if (head.len != 16'd0)
                    next_state = PLAY;
                else if (level > LW'(1))
                    next_state = LOAD;
                else
                    next_state = FINISH;
            PLAY:
                if (!run)
                    next_state = IDLE;
                else if (last)
                    next_state = GAP;
            GAP:
                if (!run)
                    next_state = IDLE;
                else if (gap_done)
                    next_state = empty ? FINISH : LOAD;
            FINISH:
                next_state = IDLE;
            default:
                next_state = IDLE;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        load_note = 1'b0;
        play      = 1'b0;
        finish    = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE:   busy = 1'b0;
            LOAD: begin
                pop       = 1'b1;
                load_note = !empty;
            end
            PLAY:   play   = 1'b1;
            FINISH: finish = 1'b1;
            default: ;
        endcase
    end

    // Counter restarts on every entry so each note/gap gets whole ticks.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n)
            tick_cnt <= '0;
        else if (next_state != state &&
                 (next_state == PLAY || next_state == GAP))
            tick_cnt <= '0;
        else if (timing_on)
            tick_cnt <= tick ? '0 : tick_cnt + 32'd1;
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            remaining  <= '0;
            cur_divide <= '0;
            cur_duty   <= '0;
        end else if (load_note) begin
            remaining  <= head.len;
            cur_divide <= head.divide;
            cur_duty   <= head.duty;
        end else if (play && last) begin
            remaining  <= 16'(GAP_TICKS);
        end else if (tick && remaining != 16'd0) begin
            remaining  <= remaining - 16'd1;
        end
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            pwm_enable       <= 1'b0;
            pwm_clock_divide <= '0;
            pwm_duty_cycle   <= '0;
        end else begin
            pwm_enable <= play && run;
            if (play) begin
                pwm_clock_divide <= cur_divide;
                pwm_duty_cycle   <= cur_duty;
            end
        end
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            stage_divide <= '0;
            stage_duty   <= '0;
            run          <= 1'b0;
            flush_q      <= 1'b0;
            ovf          <= 1'b0;
            done         <= 1'b0;
        end else begin
            unique case (1'b1)
                wr_divide: stage_divide <= avs.avs_writedata;
                wr_duty:   stage_duty   <= avs.avs_writedata;
                wr_ctrl:   run          <= avs.avs_writedata[CTRL_RUN];
                default: ;
            endcase
            flush_q <= wr_ctrl && avs.avs_writedata[CTRL_FLUSH];
            if (overflow)
                ovf <= 1'b1;
            else if (clr)
                ovf <= 1'b0;
            if (finish)
                done <= 1'b1;
            else if (clr)
                done <= 1'b0;
        end
    end

`ifdef ZIRCON_BUZZER_SEQ_IRQ_EN
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            irq_en  <= 1'b0;
            ins_irq <= 1'b0;
        end else begin
            if (wr_ctrl)
                irq_en <= avs.avs_writedata[CTRL_IRQ_EN];
            ins_irq <= done && irq_en;
        end
    end
`else
    assign irq_en  = 1'b0;
    assign ins_irq = 1'b0;
`endif

    always_comb begin
        status                   = '0;
        status[STAT_RUN]         = run;
        status[STAT_BUSY]        = busy;
        status[STAT_EMPTY]       = empty;
        status[STAT_FULL]        = full;
        status[STAT_OVF]         = ovf;
        status[STAT_DONE]        = done;
        status[STAT_IRQ_EN]      = irq_en;
        status[STAT_LEVEL +: LW] = level;
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            avs.avs_readdata <= '0;
        end else if (avs.avs_read) begin
            unique case (avs.avs_address)
                ADDR_DIVIDE: avs.avs_readdata <= stage_divide;
                ADDR_DUTY:   avs.avs_readdata <= stage_duty;
                ADDR_LEN:    avs.avs_readdata <= '0;
                default:     avs.avs_readdata <= status;
            endcase
        end
    end

endmodule

// File: tb/tb_zircon_avalon_buzzer_sequencer.sv
// Self-checking bench for the buzzer note sequencer (TICK_DIV=4, GAP=2).
module tb_zircon_avalon_buzzer_sequencer;

    logic        clk;
    logic        rst_n;
    logic        pwm_enable;
    logic [31:0] pwm_clock_divide;
    logic [31:0] pwm_duty_cycle;
    logic        ins_irq;

    int checks = 0;
    int errors = 0;

`ifdef ZIRCON_BUZZER_SEQ_IRQ_EN
    localparam logic [31:0] EXP_IRQ = 32'd1;
`else
    localparam logic [31:0] EXP_IRQ = 32'd0;
`endif

    zircon_avalon_buzzer_sequencer_if bus ();

    zircon_avalon_buzzer_sequencer #(
        .FIFO_DEPTH (8),
        .TICK_DIV   (4),
        .GAP_TICKS  (2)
    ) dut (
        .csi_clk          (clk),
        .rsi_reset_n      (rst_n),
        .avs              (bus.slave),
        .pwm_enable       (pwm_enable),
        .pwm_clock_divide (pwm_clock_divide),
        .pwm_duty_cycle   (pwm_duty_cycle),
        .ins_irq          (ins_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } rd_exp_t;

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] data;
        string       name;
    } vec_t;

    rd_exp_t sb[$];
    rd_exp_t e;
    vec_t    vecs[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (bus.avs_read) begin
            #1;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk(e.name, bus.avs_readdata & e.mask, e.exp);
            end
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] x,
                      input logic [31:0] m, input string n);
        rd_exp_t r;
        r.exp  = x;
        r.mask = m;
        r.name = n;
        sb.push_back(r);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        @(negedge clk);
        bus.avs_read    = 1'b0;
    endtask

    task automatic wait_pwm(input logic lvl, input string n);
        int i;
        i = 0;
        while (pwm_enable !== lvl && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk(n, 32'(pwm_enable === lvl), 32'd1);
    endtask

    task automatic count_high(output int n);
        n = 0;
        while (pwm_enable === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int  n;
        bit  ok;
        bit  seen;

        vecs[0]  = '{0, 2'd3, 32'h0000_0004, "rst_status"};
        vecs[1]  = '{0, 2'd0, 32'd0,         "rst_divide"};
        vecs[2]  = '{0, 2'd1, 32'd0,         "rst_duty"};
        vecs[3]  = '{1, 2'd0, 32'd99,        "wr_divide"};
        vecs[4]  = '{1, 2'd1, 32'd49,        "wr_duty"};
        vecs[5]  = '{0, 2'd0, 32'd99,        "rd_divide"};
        vecs[6]  = '{0, 2'd1, 32'd49,        "rd_duty"};
        vecs[7]  = '{0, 2'd2, 32'd0,         "rd_len"};
        vecs[8]  = '{1, 2'd2, 32'd3,         "push_note"};
        vecs[9]  = '{0, 2'd2, 32'd0,         "rd_len_after"};
        vecs[10] = '{0, 2'd3, 32'h0000_0100, "status_one"};

        rst_n             = 1'b0;
        bus.avs_address   = '0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        bus.avs_read      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_pwm_en",  32'(pwm_enable), 32'd0);
        chk("rst_divide_o", pwm_clock_divide, 32'd0);
        chk("rst_duty_o",  pwm_duty_cycle, 32'd0);
        chk("rst_irq",     32'(ins_irq), 32'd0);
        chk("rst_rdata",   bus.avs_readdata, 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].wr)
                wr(vecs[i].addr, vecs[i].data);
            else
                rd(vecs[i].addr, vecs[i].data, 32'hFFFF_FFFF, vecs[i].name);
        end

        // single note: 3 ticks of tone, 2 ticks of gap
        wr(2'd3, 32'd1);
        wait_pwm(1'b1, "single_rise");
        chk("single_div",  pwm_clock_divide, 32'd99);
        chk("single_duty", pwm_duty_cycle, 32'd49);
        count_high(n);
        chk("single_len", 32'(n), 32'd12);
        chk("gap_div_hold", pwm_clock_divide, 32'd99);
        rd(2'd3, 32'h07, 32'hFFFF_FFFF, "gap_status");
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ok &= (pwm_enable === 1'b0);
            @(negedge clk);
        end
        chk("gap_low", 32'(ok), 32'd1);
        rd(2'd3, 32'h07, 32'hFFFF_FFFF, "finish_status");
        chk("post_gap_low", 32'(pwm_enable), 32'd0);
        rd(2'd3, 32'h25, 32'hFFFF_FFFF, "single_done");
        wr(2'd3, 32'd4);
        rd(2'd3, 32'h04, 32'hFFFF_FFFF, "done_clear");

        // overflow
        for (int i = 0; i < 9; i++)
            wr(2'd2, 32'd2);
        rd(2'd3, 32'h818, 32'hFFFF_FFFF, "ovf_status");
        wr(2'd3, 32'd4);
        rd(2'd3, 32'h808, 32'hFFFF_FFFF, "ovf_clear");
        wr(2'd3, 32'd2);
        @(negedge clk);
        rd(2'd3, 32'h04, 32'hFFFF_FFFF, "flush_empty");

        // zero-length entry is skipped
        wr(2'd0, 32'd7);
        wr(2'd1, 32'd3);
        wr(2'd2, 32'd0);
        wr(2'd0, 32'd11);
        wr(2'd1, 32'd5);
        wr(2'd2, 32'd1);
        wr(2'd3, 32'd1);
        wait_pwm(1'b1, "zero_rise");
        chk("zero_div",  pwm_clock_divide, 32'd11);
        chk("zero_duty", pwm_duty_cycle, 32'd5);
        count_high(n);
        chk("zero_len", 32'(n), 32'd4);
        repeat (10) @(negedge clk);
        rd(2'd3, 32'h25, 32'hFFFF_FFFF, "zero_done");
        wr(2'd3, 32'd4);

        // stop mid-note keeps the queue
        wr(2'd0, 32'd21);
        wr(2'd1, 32'd10);
        for (int i = 0; i < 3; i++)
            wr(2'd2, 32'd5);
        wr(2'd3, 32'd1);
        wait_pwm(1'b1, "stop_rise");
        repeat (3) @(negedge clk);
        wr(2'd3, 32'd0);
        @(negedge clk);
        chk("stop_pwm_off", 32'(pwm_enable), 32'd0);
        rd(2'd3, 32'h200, 32'hFFFF_FFFF, "stop_status");
        wr(2'd3, 32'd2);
        @(negedge clk);
        rd(2'd3, 32'h04, 32'hFFFF_FFFF, "stop_flush");

        // asynchronous reset mid-note
        wr(2'd0, 32'd33);
        wr(2'd1, 32'd16);
        wr(2'd2, 32'd5);
        wr(2'd3, 32'd1);
        wait_pwm(1'b1, "rstmid_rise");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_pwm", 32'(pwm_enable), 32'd0);
        chk("rstmid_div", pwm_clock_divide, 32'd0);
        chk("rstmid_duty", pwm_duty_cycle, 32'd0);
        chk("rstmid_rdata", bus.avs_readdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rstmid_idle", 32'(pwm_enable), 32'd0);
        rd(2'd0, 32'd0, 32'hFFFF_FFFF, "rstmid_stage");
        rd(2'd3, 32'h04, 32'hFFFF_FFFF, "rstmid_status");
        wr(2'd0, 32'd44);
        wr(2'd1, 32'd22);
        wr(2'd2, 32'd1);
        wr(2'd3, 32'd1);
        wait_pwm(1'b1, "restart_rise");
        chk("restart_div", pwm_clock_divide, 32'd44);
        wait_pwm(1'b0, "restart_fall");
        repeat (12) @(negedge clk);
        wr(2'd3, 32'd4);

        // interrupt on completion (only raised when the option is built in)
        wr(2'd2, 32'd1);
        wr(2'd3, 32'd9);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            seen |= (ins_irq === 1'b1);
            @(negedge clk);
        end
        chk("irq_raise", 32'(seen), EXP_IRQ);
        wr(2'd3, 32'd12);
        repeat (2) @(negedge clk);
        chk("irq_clear", 32'(ins_irq), 32'd0);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
